// File: rtl/hall_sig_if.sv
// Hall signal generator bus: configuration handshake and generated outputs.
//   enable        master -> slave  run the generator
//   load          master -> slave  1-cycle config strobe
//   freq_hz       master -> slave  requested frequency in Hz (0 = stopped)
//   duty          master -> slave  high fraction = duty/256
//   cfg_busy      slave -> master  config engine computing or waiting to apply
//   cfg_done      slave -> master  1-cycle pulse when a new config goes live
//   out_sig       slave -> master  generated hall signal
//   period_start  slave -> master  1-cycle pulse on the first cycle of a period
interface hall_sig_if #(
   parameter int unsigned FREQ_WIDTH = 8
) ();
   logic                  enable;
   logic                  load;
   logic [FREQ_WIDTH-1:0] freq_hz;
   logic [7:0]            duty;
   logic                  cfg_busy;
   logic                  cfg_done;
   logic                  out_sig;
   logic                  period_start;

   modport master (
      output enable, load, freq_hz, duty,
      input  cfg_busy, cfg_done, out_sig, period_start
   );

   modport slave (
      input  enable, load, freq_hz, duty,
      output cfg_busy, cfg_done, out_sig, period_start
   );
endinterface

// File: rtl/hall_sig_gen.sv
// Hall-sensor tach emulator. Produces a square wave of programmed frequency
// (Hz) and duty (duty/256). A new config is turned into a period length in
// clk cycles by a 32-cycle restoring divider and a one-cycle multiply, then
// held pending until the running period wraps so the output never glitches.
// Ports:
//   clk    clock, everything on posedge
//   reset  synchronous, active-high; returns to the stopped config
//   bus    hall_sig_if slave modport (enable/load/freq_hz/duty in,
//          cfg_busy/cfg_done/out_sig/period_start out, all registered)
module hall_sig_gen #(
   parameter int unsigned FREQ_WIDTH     = 8,
   parameter int unsigned CLK_FREQ_HZ    = 100_000_000,
   parameter int unsigned MIN_PERIOD_CNT = 666_667
) (
   input  logic      clk,
   input  logic      reset,
   hall_sig_if.slave bus
);
   localparam logic [31:0] CLK_DIVIDEND = 32'(CLK_FREQ_HZ);
   localparam logic [31:0] MIN_PER      = 32'(MIN_PERIOD_CNT);

   typedef enum logic [1:0] {
      CFG_IDLE = 2'd0,
      CFG_DIV  = 2'd1,
      CFG_MUL  = 2'd2,
      CFG_PEND = 2'd3
   } cfg_state_e;

   cfg_state_e            state_q, state_d;
   logic [4:0]            bit_cnt_q, bit_cnt_d;
   logic [FREQ_WIDTH-1:0] freq_q, freq_d;
   logic [7:0]            duty_q, duty_d;
   logic [31:0]           rem_q, rem_d;
   logic [31:0]           quo_q, quo_d;
   logic [31:0]           new_per_q, new_per_d;
   logic [31:0]           new_high_q, new_high_d;
   logic                  new_stop_q, new_stop_d;
   logic [31:0]           per_q, per_d;
   logic [31:0]           high_q, high_d;
   logic                  stop_q, stop_d;
   logic [31:0]           cntr_q, cntr_d;
   logic                  run_q, run_d;
   logic                  out_sig_q, out_sig_d;
   logic                  period_start_q, period_start_d;
   logic                  cfg_busy_q, cfg_busy_d;
   logic                  cfg_done_q, cfg_done_d;
   logic                  apply_s;

   // Restoring divider step: quo_q shifts the dividend out MSB-first while
   // collecting quotient bits at the LSB end.
   logic [32:0] rem_shift_s;
   logic [32:0] divisor_s;
   logic [32:0] rem_sub_s;
   logic        rem_ge_s;
   assign rem_shift_s = {rem_q, quo_q[31]};
   assign divisor_s   = 33'(freq_q);
   assign rem_sub_s   = rem_shift_s - divisor_s;
   assign rem_ge_s    = (rem_shift_s >= divisor_s);

   // Clamp to the minimum period, then scale by duty/256.
   logic [31:0] per_clamp_s;
   logic [39:0] prod_s;
   assign per_clamp_s = (quo_q < MIN_PER) ? MIN_PER : quo_q;
   assign prod_s      = 40'(per_clamp_s) * 40'(duty_q);

   // The top remainder bit is always clear after a restoring step, and the
   // low product byte is the fraction dropped by the /256.
   logic unused_bits_s;
   assign unused_bits_s = ^{rem_sub_s[32], rem_shift_s[32], prod_s[7:0]};

   // Config FSM next state, divider and multiplier datapath.
   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      freq_d     = freq_q;
      duty_d     = duty_q;
      rem_d      = rem_q;
      quo_d      = quo_q;
      new_per_d  = new_per_q;
      new_high_d = new_high_q;
      new_stop_d = new_stop_q;
      apply_s    = 1'b0;
      case (state_q)
         CFG_IDLE: begin
            if (bus.load) begin
               state_d   = CFG_DIV;
               freq_d    = bus.freq_hz;
               duty_d    = bus.duty;
               rem_d     = 32'd0;
               quo_d     = CLK_DIVIDEND;
               bit_cnt_d = 5'd0;
            end else begin
               state_d = CFG_IDLE;
            end
         end
         CFG_DIV: begin
            if (rem_ge_s) begin
               rem_d = rem_sub_s[31:0];
            end else begin
               rem_d = rem_shift_s[31:0];
            end
            quo_d     = {quo_q[30:0], rem_ge_s};
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd31) begin
               state_d = CFG_MUL;
            end else begin
               state_d = CFG_DIV;
            end
         end
         CFG_MUL: begin
            // freq 0 ran the divider anyway (constant latency); its result is junk.
            if (freq_q == {FREQ_WIDTH{1'b0}}) begin
               new_per_d  = 32'd0;
               new_high_d = 32'd0;
               new_stop_d = 1'b1;
            end else begin
               new_per_d  = per_clamp_s;
               new_high_d = prod_s[39:8];
               new_stop_d = 1'b0;
            end
            state_d = CFG_PEND;
         end
         CFG_PEND: begin
            // Idle generator takes the config at once; a running one only
            // on the last cycle of its period so the next period is clean.
            if (!bus.enable || stop_q || (run_q && (cntr_q == per_q - 32'd1))) begin
               apply_s = 1'b1;
               state_d = CFG_IDLE;
            end else begin
               state_d = CFG_PEND;
            end
         end
         default: begin
            state_d = CFG_IDLE;
         end
      endcase
   end

   // Active config swap, period counter and registered outputs. Outputs are
   // computed from the next counter value so cfg_done, period_start and the
   // out_sig rising edge all land in the first cycle of a period.
   always_comb begin
      per_d  = per_q;
      high_d = high_q;
      stop_d = stop_q;
      cntr_d = cntr_q;
      if (apply_s) begin
         per_d      = new_per_q;
         high_d     = new_high_q;
         stop_d     = new_stop_q;
         cfg_done_d = 1'b1;
      end else begin
         cfg_done_d = 1'b0;
      end
      cfg_busy_d = (state_d != CFG_IDLE);
      run_d      = bus.enable & ~stop_d;
      if (!run_d || !run_q || apply_s) begin
         cntr_d = 32'd0;
      end else if (cntr_q == per_q - 32'd1) begin
         cntr_d = 32'd0;
      end else begin
         cntr_d = cntr_q + 32'd1;
      end
      out_sig_d      = run_d & (cntr_d < high_d);
      period_start_d = run_d & (cntr_d == 32'd0);
   end

   // Config FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= CFG_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath, active config and output registers; reset restores the stopped config.
   always_ff @(posedge clk) begin
      if (reset) begin
         bit_cnt_q      <= 5'd0;
         freq_q         <= {FREQ_WIDTH{1'b0}};
         duty_q         <= 8'd0;
         rem_q          <= 32'd0;
         quo_q          <= 32'd0;
         new_per_q      <= 32'd0;
         new_high_q     <= 32'd0;
         new_stop_q     <= 1'b1;
         per_q          <= 32'd0;
         high_q         <= 32'd0;
         stop_q         <= 1'b1;
         cntr_q         <= 32'd0;
         run_q          <= 1'b0;
         out_sig_q      <= 1'b0;
         period_start_q <= 1'b0;
         cfg_busy_q     <= 1'b0;
         cfg_done_q     <= 1'b0;
      end else begin
         bit_cnt_q      <= bit_cnt_d;
         freq_q         <= freq_d;
         duty_q         <= duty_d;
         rem_q          <= rem_d;
         quo_q          <= quo_d;
         new_per_q      <= new_per_d;
         new_high_q     <= new_high_d;
         new_stop_q     <= new_stop_d;
         per_q          <= per_d;
         high_q         <= high_d;
         stop_q         <= stop_d;
         cntr_q         <= cntr_d;
         run_q          <= run_d;
         out_sig_q      <= out_sig_d;
         period_start_q <= period_start_d;
         cfg_busy_q     <= cfg_busy_d;
         cfg_done_q     <= cfg_done_d;
      end
   end

   assign bus.cfg_busy     = cfg_busy_q;
   assign bus.cfg_done     = cfg_done_q;
   assign bus.out_sig      = out_sig_q;
   assign bus.period_start = period_start_q;
endmodule

// File: tb/tb_hall_sig_gen.sv
// Bench for hall_sig_gen with a scaled-down clock (10 kHz, minimum period 60)
// so that whole periods fit in a short run. A behavioural model tracks the
// active/pending config and the period phase as (cycle - period origin) mod
// period; a compare process checks all four outputs every cycle. Directed
// sections pin the model with hand-computed periods, high times and latency.
module tb_hall_sig_gen;
   localparam int FW      = 8;
   localparam int CLK_HZ  = 10_000;
   localparam int MIN_PER = 60;

   logic clk = 1'b0;
   logic reset;

   hall_sig_if #(.FREQ_WIDTH(FW)) bus_if ();

   hall_sig_gen #(
      .FREQ_WIDTH     (FW),
      .CLK_FREQ_HZ    (CLK_HZ),
      .MIN_PERIOD_CNT (MIN_PER)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if.slave)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   longint n       = 0;
   bit     m_valid = 1'b0;
   bit     m_busy, m_run, m_stop, m_new_stop;
   int     m_cd;
   longint m_per, m_high, m_new_per, m_new_high, m_t0;
   bit     e_out, e_ps, e_done, e_busy;

   function automatic longint period_of(input int f);
      longint q;
      if (f == 0) return 0;
      q = CLK_HZ / f;
      return (q < MIN_PER) ? longint'(MIN_PER) : q;
   endfunction

   initial begin : model
      longint ph;
      bit     applied;
      bit     run_next;
      forever begin
         @(posedge clk);
         n++;
         if (reset) begin
            m_busy = 1'b0; m_run = 1'b0; m_stop = 1'b1;
            m_per = 0; m_high = 0; m_cd = 0; m_t0 = 0;
            e_out = 1'b0; e_ps = 1'b0; e_done = 1'b0; e_busy = 1'b0;
            m_valid = 1'b1;
         end else if (m_valid) begin
            ph = m_run ? (n - 1 - m_t0) % m_per : 0;
            applied = 1'b0;
            if (m_busy) begin
               if (m_cd > 0) begin
                  m_cd--;
               end else if (!bus_if.enable || m_stop || (m_run && ph == m_per - 1)) begin
                  m_per = m_new_per; m_high = m_new_high; m_stop = m_new_stop;
                  m_busy = 1'b0; applied = 1'b1;
               end
            end else if (bus_if.load) begin
               m_new_per  = period_of(int'(bus_if.freq_hz));
               m_new_high = (m_new_per * longint'(bus_if.duty)) / 256;
               m_new_stop = (bus_if.freq_hz == 0);
               m_busy = 1'b1;
               m_cd   = 33;
            end
            run_next = bus_if.enable && !m_stop;
            if (run_next && (!m_run || applied)) m_t0 = n;
            m_run = run_next;
            ph = m_run ? (n - m_t0) % m_per : 0;
            e_ps   = m_run && (ph == 0);
            e_out  = m_run && (ph < m_high);
            e_done = applied;
            e_busy = m_busy;
         end
      end
   end

   initial begin : compare
      forever begin
         @(negedge clk);
         if (m_valid) begin
            check("out_sig", bus_if.out_sig, e_out);
            check("period_start", bus_if.period_start, e_ps);
            check("cfg_done", bus_if.cfg_done, e_done);
            check("cfg_busy", bus_if.cfg_busy, e_busy);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic do_load(input int f, input int d);
      bus_if.freq_hz = 8'(f);
      bus_if.duty    = 8'(d);
      bus_if.load    = 1'b1;
      @(negedge clk);
      bus_if.load    = 1'b0;
   endtask

   task automatic wait_done(input int limit, output int cycles);
      cycles = 0;
      while (bus_if.cfg_done !== 1'b1 && cycles < limit) begin
         @(negedge clk);
         cycles++;
      end
      if (cycles >= limit) begin
         total++; bad++;
         $display("FAIL wait_done: no cfg_done within %0d cycles", limit);
      end
   endtask

   task automatic wait_ps(input int limit);
      int c = 0;
      while (bus_if.period_start !== 1'b1 && c < limit) begin
         @(negedge clk);
         c++;
      end
      if (c >= limit) begin
         total++; bad++;
         $display("FAIL wait_ps: no period_start within %0d cycles", limit);
      end
   endtask

   // Called on a period_start cycle: length of this period and its high time.
   task automatic period_from_here(output int per, output int hi);
      per = 0; hi = 0;
      do begin
         if (bus_if.out_sig === 1'b1) hi++;
         per++;
         @(negedge clk);
      end while (bus_if.period_start !== 1'b1 && per < 5000);
   endtask

   task automatic measure(input string name, input int exp_per, input int exp_hi);
      int per, hi;
      wait_ps(5000);
      period_from_here(per, hi);
      check({name, "_period"}, per, exp_per);
      check({name, "_high"}, hi, exp_hi);
   endtask

   // ---------------- directed + random stimulus ----------------
   initial begin : stim
      int     cyc, per, hi, done_cnt, ps_cnt, out_cnt;
      longint s;
      reset = 1'b1;
      bus_if.enable = 1'b0; bus_if.load = 1'b0;
      bus_if.freq_hz = 8'd0; bus_if.duty = 8'd0;
      repeat (3) @(negedge clk);
      check("rst_out_sig", bus_if.out_sig, 0);
      check("rst_period_start", bus_if.period_start, 0);
      check("rst_cfg_busy", bus_if.cfg_busy, 0);
      check("rst_cfg_done", bus_if.cfg_done, 0);
      reset = 1'b0;
      @(negedge clk);

      // 100 Hz, 50 %: latency 34, period 100, high 50
      bus_if.enable = 1'b1;
      do_load(100, 128);
      check("busy_after_load", bus_if.cfg_busy, 1);
      wait_done(100, cyc);
      check("load_to_done", cyc, 34);
      check("done_with_ps", bus_if.period_start, 1);
      measure("f100_d128", 100, 50);

      // 200 Hz clamps to the minimum period
      do_load(200, 128);
      wait_done(500, cyc);
      check("clamp_done_with_ps", bus_if.period_start, 1);
      measure("f200_clamp", 60, 30);

      // duty boundaries
      do_load(100, 0);
      wait_done(500, cyc);
      measure("duty0", 100, 0);
      do_load(100, 255);
      wait_done(500, cyc);
      measure("duty255", 100, 99);

      // reload mid-period: current period completes, then 2x period
      do_load(100, 128);
      wait_done(500, cyc);
      wait_ps(500);
      s = n;
      repeat (30) @(negedge clk);
      do_load(50, 128);
      wait_ps(500);
      check("old_period_kept", n - s, 100);
      check("reload_done_with_ps", bus_if.cfg_done, 1);
      period_from_here(per, hi);
      check("f50_period", per, 200);
      check("f50_high", hi, 100);

      // load while busy is ignored
      do_load(200, 128);
      do_load(100, 128);
      wait_done(1000, cyc);
      measure("first_cfg_wins", 60, 30);

      // reset mid-divide
      do_load(50, 128);
      repeat (10) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("midreset_busy", bus_if.cfg_busy, 0);
      check("midreset_out", bus_if.out_sig, 0);
      reset = 1'b0;
      done_cnt = 0;
      repeat (80) begin
         @(negedge clk);
         if (bus_if.cfg_done === 1'b1) done_cnt++;
      end
      check("midreset_no_done", done_cnt, 0);

      // freq 0 while running: stops at the next boundary
      do_load(100, 128);
      wait_done(500, cyc);
      do_load(0, 128);
      done_cnt = 0; ps_cnt = 0; out_cnt = 0;
      repeat (400) begin
         if (bus_if.cfg_done === 1'b1) done_cnt++;
         if (done_cnt > 0 && bus_if.period_start === 1'b1) ps_cnt++;
         if (done_cnt > 0 && bus_if.out_sig === 1'b1) out_cnt++;
         @(negedge clk);
      end
      check("stop_done_once", done_cnt, 1);
      check("stop_no_ps", ps_cnt, 0);
      check("stop_out_low", out_cnt, 0);

      // enable off and back on
      do_load(100, 128);
      wait_done(500, cyc);
      repeat (10) @(negedge clk);
      bus_if.enable = 1'b0;
      @(negedge clk);
      check("en_off_out", bus_if.out_sig, 0);
      check("en_off_ps", bus_if.period_start, 0);
      repeat (5) @(negedge clk);
      bus_if.enable = 1'b1;
      @(negedge clk);
      check("en_on_ps", bus_if.period_start, 1);
      check("en_on_out", bus_if.out_sig, 1);

      // randomized traffic, checked every cycle by the model
      for (int i = 0; i < 15000; i++) begin
         bus_if.load = ($urandom_range(0, 39) == 0);
         if (bus_if.load) begin
            bus_if.freq_hz = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(20, 255));
            case ($urandom_range(0, 3))
               0:       bus_if.duty = 8'd0;
               1:       bus_if.duty = 8'd255;
               default: bus_if.duty = 8'($urandom_range(0, 255));
            endcase
         end
         if ($urandom_range(0, 299) == 0) bus_if.enable = ~bus_if.enable;
         reset = ($urandom_range(0, 1999) == 0);
         @(negedge clk);
      end
      reset = 1'b0;
      bus_if.load = 1'b0;
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
